usb_pkt_decoder: RTL and testbench
==================================

# usb_pkt_decoder

Parametrised serial packet decoder for the receive path, placed after the NRZI/bit-unstuffing stage. It shifts in one packet per `recving` window and validates the PID and check nibble, packet length and CRC (CRC5 for tokens, CRC16 for data). It reports handshake, token and data packets, or a coded error, with a one-cycle pulse. It supersedes the fixed 64-bit DATA0-only decoder: payload width is configurable, and it adds DATA1, tokens, STALL and error codes.

## Interface
- `DATA_BYTES`, default 8: maximum payload bytes; payload width PW = 8*DATA_BYTES.
- `clk  in  1`: clock; everything is on posedge.
- `rst_L  in  1`: reset, asynchronous, active-low.
- `pause  in  1`: stuffed-bit slot; when high, `inb` and `recving` are ignored this cycle.
- `recving  in  1`: high while packet bits are present on `inb`.
- `inb  in  1`: serial bit, each field LSB-first.
- `data  out  PW`: payload; the first payload bit received is `data[0]`.
- `nbytes  out  $clog2(DATA_BYTES+1)`: received payload byte count.
- `pid  out  4`: received PID.
- `addr  out  7`, `endp  out  4`: token fields.
- `havepkt`, `havetok`, `haveack`, `havenak`, `havestall`, `error`  out  1 each: single-cycle report pulses.
- `err_code  out  3`: 0 none, 1 PID check, 2 unknown PID, 3 length, 4 CRC.

## Operation
- PID codes: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- First 8 bits: `pid[3:0]`, then the check nibble, which must equal ~pid.
- Required lengths:
  - handshake: 8 bits.
  - token: 24 bits (addr 7, endp 4, CRC5 5).
  - data: 8 + PW + 16 bits.
- States:
  - IDLE: if `recving && !pause`, capture bit 1, counter=1, go to RECV. Otherwise clear the counter and shift registers.
  - RECV, `pause`=1: hold.
  - RECV, `pause`=0 and `recving`=1: shift the bit, count, and feed the CRC unit for bits 9 and up.
  - RECV, `pause`=0 and `recving`=0: go to EOP1 with no shift.
  - EOP1 → EOP2 → REPORT → IDLE, unconditionally.
- Bit counter saturates at MAXLEN+1, where MAXLEN = 24+PW. Bits beyond MAXLEN are not stored and force a length error.
- CRC check uses the residual method:
  - CRC5: poly x^5+x^2+1, init 0x1F, over addr+endp+CRC field; valid when residual = 5'b01100.
  - CRC16: poly x^16+x^15+x^2+1, init 0xFFFF, over payload+CRC field; valid when residual = 16'h800D.
- Error priority is 1 > 2 > 3 > 4. An error suppresses every `have*` pulse.
- `data`, `nbytes`, `pid`, `addr`, `endp` and `err_code` update only in REPORT and hold until the next REPORT.
- For data packets, the last 16 bits are the CRC and are not placed in `data`. Unfilled `data` bits are 0.

## Timing
- Reset: all outputs 0, state IDLE. Reset mid-packet aborts the packet with no report.
- Report latency: pulses are high exactly one cycle, 3 cycles after the cycle in which `recving`=0 is sampled with `pause`=0.
- `recving` is ignored during EOP1, EOP2 and REPORT. A new packet is accepted only from IDLE, so the earliest next first bit is captured the cycle after REPORT.
- `pause`=1 in IDLE delays the start. `pause`=1 together with `recving`=0 in RECV does not end the packet.
- An empty window (`recving` drops before 8 bits) reports `error`, `err_code`=3.

## Configuration
- `USB_PKT_VARLEN_EN` defined:
  - data packets may carry any whole byte count 0..DATA_BYTES; required length is 24 + 8n.
  - `nbytes`=n.
  - CRC16 is applied to the last 16 received bits.
  - a non-byte-multiple or oversized length gives `err_code` 3.
- Undefined: data length must be exactly 8+PW+16 and `nbytes` is always DATA_BYTES.

## Test plan
- ACK: wire byte 0xD2 LSB-first, 8 bits → `haveack` pulse 3 cycles after `recving` falls; `pid`=0010; `err_code`=0.
- OUT token with addr 0x3A, endp 0x1 and correct CRC5 → `havetok`, `addr`=7'h3A, `endp`=4'h1. Flip one CRC bit → `error`, `err_code`=4.
- DATA0 with DATA_BYTES=8, bytes 01..08 and correct CRC16 → `havepkt`, `data`=64'h0807060504030201, `nbytes`=8. Flip payload bit 5 → `err_code`=4.
- Check nibble corrupted (wire 0xC2) → `err_code`=1. A 9-bit ACK → `err_code`=3. A 200-bit window → `err_code`=3, no hang.
- `pause` high for 3 cycles mid-payload, then repeat the DATA0 case → identical result, with latency measured from the final `recving` fall.
- `rst_L` low mid-packet → no pulses, all outputs 0. The next ACK decodes normally.
- With `USB_PKT_VARLEN_EN`: DATA1 with 2 bytes AB CD → `havepkt`, `nbytes`=2, `data[15:0]`=16'hCDAB, upper bits 0.

Source files
------------

// File: rtl/usb_pkt_decoder.sv
// Serial USB packet decoder: PID/check, length and CRC5/CRC16 validation with one-cycle report pulses.
// Optional build macro USB_PKT_VARLEN_EN enables variable-length data payloads (0..DATA_BYTES bytes).
module usb_pkt_decoder #(
    parameter int DATA_BYTES = 8
) (
    input  logic                              clk,
    input  logic                              rst_L,
    input  logic                              pause,
    input  logic                              recving,
    input  logic                              inb,
    output logic [8*DATA_BYTES-1:0]           data,
    output logic [$clog2(DATA_BYTES+1)-1:0]   nbytes,
    output logic [3:0]                        pid,
    output logic [6:0]                        addr,
    output logic [3:0]                        endp,
    output logic                              havepkt,
    output logic                              havetok,
    output logic                              haveack,
    output logic                              havenak,
    output logic                              havestall,
    output logic                              error,
    output logic [2:0]                        err_code
);
    localparam int PW     = 8 * DATA_BYTES;
    localparam int MAXLEN = 24 + PW;
    localparam int SW     = 8 + PW;
    localparam int CW     = $clog2(MAXLEN + 2);
    localparam int NBW    = $clog2(DATA_BYTES + 1);

    localparam logic [CW-1:0] LEN_HS    = CW'(8);
    localparam logic [CW-1:0] LEN_TOK   = CW'(24);
    localparam logic [CW-1:0] LEN_MAX   = CW'(MAXLEN);
    localparam logic [CW-1:0] LEN_SAT   = CW'(MAXLEN + 1);
    localparam logic [CW-1:0] LEN_STORE = CW'(SW);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_EOP1, S_EOP2, S_REPORT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    shreg;
    logic [4:0]       crc5;
    logic [15:0]      crc16;

    logic             capture;
    logic             shift_en;
    logic [3:0]       rx_pid;
    logic             is_tok, is_dat, is_hs;
    logic             dat_len_ok, len_ok, crc_ok;
    logic [2:0]       code;
    logic [PW-1:0]    payload;
    logic [NBW-1:0]   nb;
`ifdef USB_PKT_VARLEN_EN
    logic [CW-1:0]    nbits;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == LEN_SAT) ? c : c + 1'b1;
    endfunction

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    assign capture  = (state == S_IDLE) && recving && !pause;
    assign shift_en = (state == S_RECV) && recving && !pause;
    assign rx_pid   = shreg[3:0];
    assign is_tok   = (rx_pid == PID_OUT) || (rx_pid == PID_IN);
    assign is_dat   = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
    assign is_hs    = (rx_pid == PID_ACK) || (rx_pid == PID_NAK) || (rx_pid == PID_STALL);

    // Bit store and running CRCs; the CRCs see every bit after the PID byte.
    always_ff @(posedge clk) begin
        if (capture) begin
            shreg <= SW'(inb);
            crc5  <= 5'h1F;
            crc16 <= 16'hFFFF;
        end else if (state == S_IDLE) begin
            shreg <= '0;
            crc5  <= 5'h1F;
            crc16 <= 16'hFFFF;
        end else if (shift_en) begin
            if (cnt < LEN_STORE) begin
                shreg[cnt] <= inb;
            end
            if ((cnt >= LEN_HS) && (cnt < LEN_MAX)) begin
                crc5  <= crc5_step(crc5, inb);
                crc16 <= crc16_step(crc16, inb);
            end
        end
    end

    // Packet classification, evaluated while the FSM sits in REPORT.
    always_comb begin
        payload = shreg[8 +: PW];
        nb      = NBW'(DATA_BYTES);
        code    = 3'd0;
`ifdef USB_PKT_VARLEN_EN
        nbits      = cnt - LEN_TOK;
        dat_len_ok = (cnt >= LEN_TOK) && (cnt <= LEN_MAX) && (cnt[2:0] == 3'b000);
        nb         = dat_len_ok ? NBW'(nbits >> 3) : '0;
        for (int i = 0; i < PW; i++) begin
            if (CW'(i) >= nbits) begin
                payload[i] = 1'b0;
            end
        end
`else
        dat_len_ok = (cnt == LEN_MAX);
`endif
        len_ok = is_hs ? (cnt == LEN_HS) : (is_tok ? (cnt == LEN_TOK) : dat_len_ok);
        crc_ok = is_tok ? (crc5 == 5'b01100) : (is_dat ? (crc16 == 16'h800D) : 1'b1);
        if (cnt < LEN_HS) begin
            code = 3'd3;
        end else if (shreg[7:4] != ~rx_pid) begin
            code = 3'd1;
        end else if (!(is_tok || is_dat || is_hs)) begin
            code = 3'd2;
        end else if (!len_ok) begin
            code = 3'd3;
        end else if (!crc_ok) begin
            code = 3'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= S_IDLE;
            cnt       <= '0;
            data      <= '0;
            nbytes    <= '0;
            pid       <= '0;
            addr      <= '0;
            endp      <= '0;
            err_code  <= '0;
            havepkt   <= 1'b0;
            havetok   <= 1'b0;
            haveack   <= 1'b0;
            havenak   <= 1'b0;
            havestall <= 1'b0;
            error     <= 1'b0;
        end else begin
            havepkt   <= 1'b0;
            havetok   <= 1'b0;
            haveack   <= 1'b0;
            havenak   <= 1'b0;
            havestall <= 1'b0;
            error     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        cnt   <= CW'(1);
                        state <= S_RECV;
                    end else begin
                        cnt <= '0;
                    end
                end
                S_RECV: begin
                    if (!pause) begin
                        if (recving) begin
                            cnt <= sat_inc(cnt);
                        end else begin
                            state <= S_EOP1;
                        end
                    end
                end
                S_EOP1:  state <= S_EOP2;
                S_EOP2:  state <= S_REPORT;
                S_REPORT: begin
                    state     <= S_IDLE;
                    pid       <= rx_pid;
                    addr      <= shreg[14:8];
                    endp      <= shreg[18:15];
                    data      <= payload;
                    nbytes    <= nb;
                    err_code  <= code;
                    error     <= (code != 3'd0);
                    havepkt   <= (code == 3'd0) && is_dat;
                    havetok   <= (code == 3'd0) && is_tok;
                    haveack   <= (code == 3'd0) && (rx_pid == PID_ACK);
                    havenak   <= (code == 3'd0) && (rx_pid == PID_NAK);
                    havestall <= (code == 3'd0) && (rx_pid == PID_STALL);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_pkt_decoder.sv
// Scoreboard bench for usb_pkt_decoder: the driver queues expected reports, a monitor checks each pulse.
module tb_usb_pkt_decoder;
    localparam logic [5:0] F_PKT = 6'b100000;
    localparam logic [5:0] F_TOK = 6'b010000;
    localparam logic [5:0] F_ACK = 6'b001000;
    localparam logic [5:0] F_NAK = 6'b000100;
    localparam logic [5:0] F_STL = 6'b000010;
    localparam logic [5:0] F_ERR = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        pause = 1'b0;
    logic        recving = 1'b0;
    logic        inb = 1'b0;
    logic [63:0] data;
    logic [3:0]  nbytes;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic        havepkt, havetok, haveack, havenak, havestall, error;
    logic [2:0]  err_code;
    logic [5:0]  flags;

    typedef struct {
        logic [5:0]  flags;
        logic [2:0]  code;
        logic [3:0]  pid;
        bit          chk_tok;
        logic [6:0]  addr;
        logic [3:0]  endp;
        bit          chk_dat;
        logic [63:0] data;
        logic [3:0]  nb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    bit   pk[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    usb_pkt_decoder #(.DATA_BYTES(8)) dut (
        .clk(clk), .rst_L(rst_L), .pause(pause), .recving(recving), .inb(inb),
        .data(data), .nbytes(nbytes), .pid(pid), .addr(addr), .endp(endp),
        .havepkt(havepkt), .havetok(havetok), .haveack(haveack), .havenak(havenak),
        .havestall(havestall), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign flags = {havepkt, havetok, haveack, havenak, havestall, error};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] f, input logic [2:0] c, input logic [3:0] p);
        exp_t r;
        r.flags = f; r.code = c; r.pid = p;
        r.chk_tok = 1'b0; r.addr = '0; r.endp = '0;
        r.chk_dat = 1'b0; r.data = '0; r.nb = '0; r.cyc = 0;
        return r;
    endfunction

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) pk.push_back(b[i]);
    endtask

    // CRC16 generator over everything after the PID byte; the complemented CRC goes out MSB first.
    task automatic add_crc16();
        logic [15:0] c;
        logic        fb;
        int          n;
        c = 16'hFFFF;
        n = pk.size();
        for (int i = 8; i < n; i++) begin
            fb = pk[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        for (int i = 15; i >= 0; i--) pk.push_back(~c[i]);
    endtask

    task automatic send(input exp_t e, input int pre, input int pause_at, input int pause_len);
        exp_t x;
        x = e;
        for (int k = 0; k < pre; k++) begin
            pause = 1'b1; recving = 1'b1; inb = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < pk.size(); i++) begin
            if (i == pause_at) begin
                for (int k = 0; k < pause_len; k++) begin
                    pause = 1'b1; recving = k[0]; inb = ~pk[i];
                    @(negedge clk);
                end
            end
            pause = 1'b0; recving = 1'b1; inb = pk[i];
            @(negedge clk);
        end
        pause = 1'b0; recving = 1'b0; inb = 1'b0;
        x.cyc = cyc + 4;
        sb.push_back(x);
        repeat (6) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_L && (flags != 6'b0)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got flags %b with no report pending", flags);
            end else begin
                e = sb.pop_front();
                check("flags", 64'(flags), 64'(e.flags));
                check("err_code", 64'(err_code), 64'(e.code));
                check("pid", 64'(pid), 64'(e.pid));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_tok) begin
                    check("addr", 64'(addr), 64'(e.addr));
                    check("endp", 64'(endp), 64'(e.endp));
                end
                if (e.chk_dat) begin
                    check("data", data, e.data);
                    check("nbytes", 64'(nbytes), 64'(e.nb));
                end
            end
        end
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_data", data, 64'h0);
        check("rst_nbytes", 64'(nbytes), 64'h0);
        check("rst_pid", 64'(pid), 64'h0);
        check("rst_addr", 64'(addr), 64'h0);
        check("rst_endp", 64'(endp), 64'h0);
        check("rst_err_code", 64'(err_code), 64'h0);
        check("rst_flags", 64'(flags), 64'h0);
        rst_L = 1'b1;
        repeat (2) @(negedge clk);

        // Handshakes
        pk.delete(); add_byte(8'hD2); send(mk(F_ACK, 3'd0, 4'h2), 0, -1, 0);
        pk.delete(); add_byte(8'h5A); send(mk(F_NAK, 3'd0, 4'hA), 0, -1, 0);
        pk.delete(); add_byte(8'h1E); send(mk(F_STL, 3'd0, 4'hE), 0, -1, 0);

        // Tokens: OUT addr 0 endp 0 (CRC5 field 00010), OUT/IN addr 3A endp 1 (CRC5 field 00000)
        pk.delete(); add_byte(8'hE1); add_byte(8'h00); add_byte(8'h10);
        e = mk(F_TOK, 3'd0, 4'h1); e.chk_tok = 1'b1; e.addr = 7'h00; e.endp = 4'h0;
        send(e, 0, -1, 0);
        pk.delete(); add_byte(8'hE1); add_byte(8'hBA); add_byte(8'h00);
        e = mk(F_TOK, 3'd0, 4'h1); e.chk_tok = 1'b1; e.addr = 7'h3A; e.endp = 4'h1;
        send(e, 0, -1, 0);
        pk.delete(); add_byte(8'h69); add_byte(8'hBA); add_byte(8'h00);
        e = mk(F_TOK, 3'd0, 4'h9); e.chk_tok = 1'b1; e.addr = 7'h3A; e.endp = 4'h1;
        send(e, 0, -1, 0);
        pk.delete(); add_byte(8'hE1); add_byte(8'hBA); add_byte(8'h00); pk[23] = ~pk[23];
        send(mk(F_ERR, 3'd4, 4'h1), 0, -1, 0);

        // Full DATA0, then payload bit 5 flipped
        pk.delete(); add_byte(8'hC3);
        for (int b = 1; b <= 8; b++) add_byte(8'(b));
        add_crc16();
        e = mk(F_PKT, 3'd0, 4'h3); e.chk_dat = 1'b1; e.data = 64'h0807060504030201; e.nb = 4'd8;
        send(e, 0, -1, 0);
        pk[13] = ~pk[13];
        send(mk(F_ERR, 3'd4, 4'h3), 0, -1, 0);

        // Same DATA0 with pause before start and a 3-cycle pause mid-payload
        pk[13] = ~pk[13];
        send(e, 2, 30, 3);

        // PID and length errors
        pk.delete(); add_byte(8'hC2); send(mk(F_ERR, 3'd1, 4'h2), 0, -1, 0);
        pk.delete(); add_byte(8'hF0); send(mk(F_ERR, 3'd2, 4'h0), 0, -1, 0);
        pk.delete(); add_byte(8'hD2); pk.push_back(1'b0); send(mk(F_ERR, 3'd3, 4'h2), 0, -1, 0);
        pk.delete(); add_byte(8'hD2); for (int i = 0; i < 192; i++) pk.push_back(1'b0);
        send(mk(F_ERR, 3'd3, 4'h2), 0, -1, 0);
        pk.delete(); pk.push_back(1'b0); pk.push_back(1'b1); pk.push_back(1'b0);
        send(mk(F_ERR, 3'd3, 4'h2), 0, -1, 0);
        pk.delete(); add_byte(8'hC3); for (int i = 0; i < 17; i++) pk.push_back(1'b0);
        send(mk(F_ERR, 3'd3, 4'h3), 0, -1, 0);

        // Short data packets: valid only in the variable-length build
        pk.delete(); add_byte(8'h4B); add_byte(8'hAB); add_byte(8'hCD); add_crc16();
`ifdef USB_PKT_VARLEN_EN
        e = mk(F_PKT, 3'd0, 4'hB); e.chk_dat = 1'b1; e.data = 64'h000000000000CDAB; e.nb = 4'd2;
`else
        e = mk(F_ERR, 3'd3, 4'hB);
`endif
        send(e, 0, -1, 0);
        pk.delete(); add_byte(8'hC3); add_crc16();
`ifdef USB_PKT_VARLEN_EN
        e = mk(F_PKT, 3'd0, 4'h3); e.chk_dat = 1'b1; e.data = 64'h0; e.nb = 4'd0;
`else
        e = mk(F_ERR, 3'd3, 4'h3);
`endif
        send(e, 0, -1, 0);

        // Good DATA0 so outputs are non-zero, then reset in the middle of the next packet
        pk.delete(); add_byte(8'hC3);
        for (int b = 1; b <= 8; b++) add_byte(8'(b));
        add_crc16();
        e = mk(F_PKT, 3'd0, 4'h3); e.chk_dat = 1'b1; e.data = 64'h0807060504030201; e.nb = 4'd8;
        send(e, 0, -1, 0);
        for (int i = 0; i < 20; i++) begin
            pause = 1'b0; recving = 1'b1; inb = pk[i];
            @(negedge clk);
        end
        rst_L = 1'b0;
        recving = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data", data, 64'h0);
        check("midrst_nbytes", 64'(nbytes), 64'h0);
        check("midrst_pid", 64'(pid), 64'h0);
        check("midrst_addr_endp", 64'({addr, endp}), 64'h0);
        check("midrst_err_code", 64'(err_code), 64'h0);
        check("midrst_flags", 64'(flags), 64'h0);
        rst_L = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_pulse", 64'(flags), 64'h0);
        pk.delete(); add_byte(8'hD2); send(mk(F_ACK, 3'd0, 4'h2), 0, -1, 0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
